// File: rtl/natural_exp.sv
// natural_exp: pipelined fixed-point e^x for 8-fractional-bit unsigned inputs.
// e^x is evaluated as 2^(x*log2(e)). The integer part of the exponent becomes
// a left shift. The fractional part comes from a 64-interval 2^f table with
// linear interpolation. Sample accepted at edge t leaves at edge t+4.
module natural_exp #(
    parameter int LUT_BITS = 6
) (
    input  logic        clk,
    input  logic        I_RSTn,
    input  logic        in_valid,
    input  logic [11:0] in_8_shifted,
    output logic        out_valid,
    output logic [23:0] out_8_shifted
);

    localparam int          STAGES           = 4;
    localparam int          R_BITS           = 16 - LUT_BITS;
    localparam logic [16:0] LOG2E_16_SHIFTED = 17'd94548;

    // round(65536 * 2^(i/64)), i = 0..64; 16 fractional bits
    function automatic logic [16:0] lut_rom(input logic [6:0] idx);
        case (idx)
            7'd0:  lut_rom = 17'd65536;   7'd1:  lut_rom = 17'd66250;
            7'd2:  lut_rom = 17'd66971;   7'd3:  lut_rom = 17'd67700;
            7'd4:  lut_rom = 17'd68438;   7'd5:  lut_rom = 17'd69183;
            7'd6:  lut_rom = 17'd69936;   7'd7:  lut_rom = 17'd70698;
            7'd8:  lut_rom = 17'd71468;   7'd9:  lut_rom = 17'd72246;
            7'd10: lut_rom = 17'd73032;   7'd11: lut_rom = 17'd73828;
            7'd12: lut_rom = 17'd74632;   7'd13: lut_rom = 17'd75444;
            7'd14: lut_rom = 17'd76266;   7'd15: lut_rom = 17'd77096;
            7'd16: lut_rom = 17'd77936;   7'd17: lut_rom = 17'd78785;
            7'd18: lut_rom = 17'd79642;   7'd19: lut_rom = 17'd80510;
            7'd20: lut_rom = 17'd81386;   7'd21: lut_rom = 17'd82273;
            7'd22: lut_rom = 17'd83169;   7'd23: lut_rom = 17'd84074;
            7'd24: lut_rom = 17'd84990;   7'd25: lut_rom = 17'd85915;
            7'd26: lut_rom = 17'd86851;   7'd27: lut_rom = 17'd87796;
            7'd28: lut_rom = 17'd88752;   7'd29: lut_rom = 17'd89719;
            7'd30: lut_rom = 17'd90696;   7'd31: lut_rom = 17'd91684;
            7'd32: lut_rom = 17'd92682;   7'd33: lut_rom = 17'd93691;
            7'd34: lut_rom = 17'd94711;   7'd35: lut_rom = 17'd95743;
            7'd36: lut_rom = 17'd96785;   7'd37: lut_rom = 17'd97839;
            7'd38: lut_rom = 17'd98905;   7'd39: lut_rom = 17'd99982;
            7'd40: lut_rom = 17'd101070;  7'd41: lut_rom = 17'd102171;
            7'd42: lut_rom = 17'd103283;  7'd43: lut_rom = 17'd104408;
            7'd44: lut_rom = 17'd105545;  7'd45: lut_rom = 17'd106694;
            7'd46: lut_rom = 17'd107856;  7'd47: lut_rom = 17'd109031;
            7'd48: lut_rom = 17'd110218;  7'd49: lut_rom = 17'd111418;
            7'd50: lut_rom = 17'd112631;  7'd51: lut_rom = 17'd113858;
            7'd52: lut_rom = 17'd115098;  7'd53: lut_rom = 17'd116351;
            7'd54: lut_rom = 17'd117618;  7'd55: lut_rom = 17'd118899;
            7'd56: lut_rom = 17'd120194;  7'd57: lut_rom = 17'd121502;
            7'd58: lut_rom = 17'd122825;  7'd59: lut_rom = 17'd124163;
            7'd60: lut_rom = 17'd125515;  7'd61: lut_rom = 17'd126882;
            7'd62: lut_rom = 17'd128263;  7'd63: lut_rom = 17'd129660;
            default: lut_rom = 17'd131072;
        endcase
    endfunction

    logic [STAGES:0]       vld_pipe;
    logic [11:0]           s0_x;
    logic [28:0]           prod;
    logic [4:0]            s1_n, s2_n, s3_n;
    logic [15:0]           s1_f;
    logic [LUT_BITS-1:0]   k;
    logic [16:0]           s2_lo;
    logic [10:0]           s2_diff;
    logic [R_BITS-1:0]     s2_r;
    logic [16:0]           s3_m;

    assign k         = s1_f[15:R_BITS];
    assign out_valid = vld_pipe[STAGES];

    // y = x * log2(e) with 24 fractional bits; bits [28:24] are the shift count
    always_comb begin
        prod = {17'd0, s0_x} * {12'd0, LOG2E_16_SHIFTED};
    end

    // Valid strobe travels alongside the data; reset drops in-flight samples
    always_ff @(posedge clk or negedge I_RSTn) begin
        if (!I_RSTn) vld_pipe <= '0;
        else         vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
    end

    // Data stages load every cycle; only the output register is qualified
    always_ff @(posedge clk or negedge I_RSTn) begin
        if (!I_RSTn) begin
            s0_x    <= '0;
            s1_n    <= '0;
            s1_f    <= '0;
            s2_n    <= '0;
            s2_lo   <= '0;
            s2_diff <= '0;
            s2_r    <= '0;
            s3_n    <= '0;
            s3_m    <= '0;
        end else begin
            s0_x    <= in_8_shifted;
            s1_n    <= 5'(prod >> 24);
            s1_f    <= 16'(prod >> 8);
            s2_n    <= s1_n;
            s2_r    <= s1_f[R_BITS-1:0];
            s2_lo   <= lut_rom(7'(k));
            // adjacent entries differ by at most 1412, so 11 bits hold the slope
            s2_diff <= 11'(lut_rom(7'(k) + 7'd1) - lut_rom(7'(k)));
            s3_n    <= s2_n;
            s3_m    <= s2_lo + 17'(({10'd0, s2_diff} * {11'd0, s2_r}) >> R_BITS);
        end
    end

    // Shift 2^f by n and drop 8 fractional bits; n >= 16 overflows 24 bits
    always_ff @(posedge clk or negedge I_RSTn) begin
        if (!I_RSTn) begin
            out_8_shifted <= '0;
        end else if (vld_pipe[STAGES-1]) begin
            if (s3_n[4]) out_8_shifted <= 24'hFFFFFF;
            else         out_8_shifted <= 24'(({15'd0, s3_m} << s3_n[3:0]) >> 8);
        end
    end

endmodule
